// File: rtl/multicycle_main_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS main control FSM.
// The master side is the control unit; the slave side is the datapath and memory.
interface multicycle_main_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_src, iord,
               mem_read, mem_write, mem_size, ir_write, reg_write,
               reg_dst, mem_to_reg, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_src, iord,
               mem_read, mem_write, mem_size, ir_write, reg_write,
               reg_dst, mem_to_reg, illegal_op, state
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional macro ILLEGAL_OP_TRAP_EN: unsupported opcodes trap (sticky illegal_op) instead of NOP.
module multicycle_main_control (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_main_control_if.master  bus
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ST_W    = 4;
    localparam int unsigned ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
    localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_SH    = 6'b101001;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b110;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [OP_W-1:0]   op_q;

    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         mem_size;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;

    // Memory-class opcodes: bit 3 separates stores (101xxx) from loads (100xxx).
    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic [1:0] size_of(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        sz = SIZE_WORD;
        case (op)
            OP_LHU, OP_SH: sz = SIZE_HALF;
            OP_LBU, OP_SB: sz = SIZE_BYTE;
            default:       sz = SIZE_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [ALUOP_W-1:0] iexec_alu_op(input logic [OP_W-1:0] op);
        logic [ALUOP_W-1:0] a;
        a = ALU_ADD;
        case (op)
            OP_ANDI:            a = ALU_AND;
            OP_ORI:             a = ALU_OR;
            OP_SLTI, OP_SLTIU:  a = ALU_SLT;
            default:            a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic state_t decode_next(input logic [OP_W-1:0] op);
        state_t n;
        n = FETCH;
        case (op)
            OP_RTYPE:                                n = RTEXEC;
            OP_LW, OP_LBU, OP_LHU, OP_SW, OP_SB, OP_SH: n = MEMADR;
            OP_BEQ, OP_BNE:                          n = BRANCH;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
            OP_SLTI, OP_SLTIU, OP_LUI:               n = IEXEC;
            OP_J:                                    n = JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
            default:                                 n = TRAP;
`else
            default:                                 n = FETCH;
`endif
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is only guaranteed valid from DECODE on; hold it for the rest of the instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
        end else if (state_q == DECODE) begin
            op_q <= bus.opcode;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_d == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

    // Next state and Moore decode; reset forces every enable and select low.
    always_comb begin
        state_d    = state_q;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = SIZE_WORD;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                    if (bus.mem_ready) begin
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b = SRCB_IMMSH2;
                    state_d   = decode_next(bus.opcode);
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = is_store(op_q) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    mem_size = size_of(op_q);
                    if (bus.mem_ready) begin
                        state_d = MEMWB;
                    end
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = FETCH;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    mem_size  = size_of(op_q);
                    if (bus.mem_ready) begin
                        state_d = FETCH;
                    end
                end
                RTEXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RTYPE;
                    state_d   = RTWB;
                end
                RTWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = FETCH;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = ((op_q == OP_BEQ) && bus.zero) ||
                                ((op_q == OP_BNE) && !bus.zero);
                    state_d   = FETCH;
                end
                IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = iexec_alu_op(op_q);
                    state_d   = IWB;
                end
                IWB: begin
                    reg_write = 1'b1;
                    state_d   = FETCH;
                end
                JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                    state_d  = FETCH;
                end
                TRAP: begin
                    state_d = TRAP;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign bus.alu_op     = alu_op;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_size   = mem_size;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.state      = ST_W'(state_q);

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the MIPS core, directly upstream of the ALU control unit.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives the 3-bit ALUOp consumed by the ALU control unit, plus all datapath write enables and mux selects.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- none (opcode and ALUOp encodings fixed below)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; asynchronous, active-high
- opcode  in  6  instr[31:26] from IR; valid from DECODE onward
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- alu_op  out  3  to ALU control unit: 000 add, 001 sub, 010 R-type(func), 100 and, 101 or, 110 slt
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_write  out  1  PC load enable
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_size  out  2  00=word, 01=half, 10=byte
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- illegal_op  out  1  sticky illegal-opcode flag (only with optional feature)
- state  out  4  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, TRAP=12.
- Reset:
  - rst=1 forces state=FETCH asynchronously, clears the opcode register and illegal_op.
  - While rst=1, all enables (pc_write, ir_write, mem_read, mem_write, reg_write) are 0 and every select/alu_op output is 0.
  - Reset mid-instruction abandons it; no write occurs.
- Output decoding: outputs are decoded from state; the only Mealy terms are pc_write (gated by mem_ready in FETCH, by zero in BRANCH) and ir_write (gated by mem_ready).
- FETCH:
  - mem_read=1, iord=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00, pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Captures opcode into an internal register; alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 -> RTEXEC
    - 100011 (lw), 100100 (lbu), 100101 (lhu), 101011 (sw), 101000 (sb), 101001 (sh) -> MEMADR
    - 000100 (beq), 000101 (bne) -> BRANCH
    - 001000 (addi), 001001 (addiu), 001100 (andi), 001101 (ori), 001010 (slti), 001011 (sltiu), 001111 (lui) -> IEXEC
    - 000010 (j) -> JUMP
    - anything else: see Optional Feature
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Loads -> MEMRD, stores -> MEMWR.
- MEMRD: iord=1, mem_read=1, mem_size from latched opcode; holds until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: iord=1, mem_write=1, mem_size set; holds until mem_ready, then -> FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10; alu_op as follows, then -> IWB.
  - addi/addiu/lui: 000
  - andi: 100
  - ori: 101
  - slti/sltiu: 110
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01; pc_write = (beq & zero) | (bne & ~zero); -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- Latencies (cycles, mem_ready always 1): R-type 4, I-ALU 4, load 5, store 4, branch 3, jump 3. Each cycle of mem_ready=0 adds one stall cycle in FETCH/MEMRD/MEMWR.
- Stall rule: mem_read/mem_write and the address select stay constant for the whole stall.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unsupported opcode in DECODE -> TRAP. TRAP sets illegal_op=1 (sticky) with all enables 0, and stays in TRAP until rst.
- Undefined: an unsupported opcode in DECODE -> FETCH (executes as a NOP, 2 cycles); illegal_op tied 0; TRAP is unreachable.

Test Plan:
- Reset: assert rst mid-MEMRD of lw -> state=0 immediately, reg_write never asserted, all enables 0 until rst drops; first edge after release performs FETCH.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=010 in RTEXEC; reg_write=1 with reg_dst=1 only in RTWB; 4 cycles total.
- Load with stalls: lw (100011), mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with iord=1, mem_read=1, mem_size=00; then MEMWB with mem_to_reg=1; lbu gives mem_size=10.
- Branches: beq with zero=1 -> pc_write=1, pc_src=01, alu_op=001 in BRANCH; beq zero=0 -> pc_write=0; bne zero=0 -> pc_write=1.
- I-type ALUOp mapping: andi->100, ori->101, slti->110, sltiu->110, addi/addiu/lui->000 in IEXEC; sw (101011) -> MEMWR with mem_write=1, no reg_write.
- Illegal opcode 111111: with ILLEGAL_OP_TRAP_EN -> state 12, illegal_op=1, held until rst; without it -> back to FETCH after DECODE, illegal_op=0.
